// File: rtl/qracc_sram_seq.sv
// SRAM access sequencer: turns one handshaked read/write request into a timed
// precharge -> wordline -> sense sequence on the analog array controls.
module qracc_sram_seq #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int PchCycles = 2,
  parameter int WlCycles  = 2,
  parameter int SaCycles  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [numCols-1:0]         wr_mask_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       busy_o,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int AW   = $clog2(numRows);
  localparam int MAXC = (PchCycles > WlCycles)
                      ? ((PchCycles > SaCycles) ? PchCycles : SaCycles)
                      : ((WlCycles  > SaCycles) ? WlCycles  : SaCycles);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PCH_LOAD = CW'(PchCycles - 1);
  localparam logic [CW-1:0] WL_LOAD  = CW'(WlCycles - 1);
  localparam logic [CW-1:0] SA_LOAD  = CW'(SaCycles - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRECH  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] SENSE  = 2'd3;

  logic [1:0]         state, nxt_state;
  logic [CW-1:0]      cnt, nxt_cnt;
  logic               capture;
  logic               wr_q;
  logic [AW-1:0]      addr_q;
  logic [numCols-1:0] data_q, mask_q;
  logic [numRows-1:0] wl_vec;

  assign rq_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);

  // Row decode; an address beyond numRows matches no row, so WL stays all-zero.
  always_comb begin
    wl_vec = '0;
    for (int unsigned r = 0; r < numRows; r++) begin
      wl_vec[r] = (addr_q == AW'(r));
    end
  end

  // Phase sequencing with a single down-counter reloaded on each phase entry.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (rq_valid_i) begin
          nxt_state = PRECH;
          nxt_cnt   = PCH_LOAD;
        end
      end
      PRECH: begin
        if (cnt == '0) begin
          nxt_state = ACCESS;
          nxt_cnt   = WL_LOAD;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          nxt_state = wr_q ? IDLE : SENSE;
          nxt_cnt   = wr_q ? '0 : SA_LOAD;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      default: begin
        if (cnt == '0) begin
          nxt_state = IDLE;
          capture   = 1'b1;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
    endcase
  end

  // State, request latch and registered array controls (decoded from the next state
  // so each control lines up with the phase it belongs to).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      WL         <= '0;
      PCH        <= 1'b0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      CSEL       <= '0;
      SAEN       <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (state == IDLE && rq_valid_i) begin
        wr_q   <= rq_wr_i;
        addr_q <= addr_i;
        data_q <= wr_data_i;
        mask_q <= wr_mask_i;
      end
      PCH     <= (nxt_state == PRECH);
      WL      <= (nxt_state == ACCESS || nxt_state == SENSE) ? wl_vec : '0;
      WRITE   <= (nxt_state == ACCESS) && wr_q;
      WR_DATA <= ((nxt_state == ACCESS) && wr_q) ? (data_q & mask_q) : '0;
      if (nxt_state == ACCESS) begin
        CSEL <= wr_q ? mask_q : '1;
      end else if (nxt_state == SENSE) begin
        CSEL <= '1;
      end else begin
        CSEL <= '0;
      end
      SAEN       <= (nxt_state == SENSE);
      rd_valid_o <= capture;
      if (capture) begin
        rd_data_o <= (|wl_vec) ? SA_OUT : '0;
      end
    end
  end

endmodule
